// File: rtl/branch_predictor.sv
// branch_predictor: table of saturating counters looked up in Fetch with
// bimodal or gshare indexing, a registered Decode-stage prediction, training
// from the resolved branch outcome, and branch / mispredict statistics.
module branch_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int CTR_BITS   = 2,
   parameter int HIST_BITS  = 4,
   parameter int MODE       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           pcF,
   input  logic                  stallD,
   input  logic                  flushD,
   output logic                  pred_takeD,
   output logic [INDEX_BITS-1:0] pred_indexD,
   input  logic                  update_en,
   input  logic [INDEX_BITS-1:0] update_index,
   input  logic                  update_taken,
   input  logic                  update_mispredict,
   output logic [31:0]           branch_count,
   output logic [31:0]           mispred_count
);

   localparam int                  ENTRIES  = 1 << INDEX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

   // Saturating up/down step of one counter.
   function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c,
                                                    input logic                up);
      if (up) return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
      else    return (c == '0)      ? c : c - CTR_BITS'(1);
   endfunction

   logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
   logic [CTR_BITS-1:0]   ctr_upd_d;
   logic [HIST_BITS-1:0]  ghr_q, ghr_d;
   logic [INDEX_BITS-1:0] idxF;
   logic                  predF;
   logic                  pred_take_q, pred_take_d;
   logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
   logic [31:0]           branch_count_q, branch_count_d;
   logic [31:0]           mispred_count_q, mispred_count_d;
   logic                  unused_pc;

   // PC bits outside the index field play no part in the lookup.
   assign unused_pc = ^{pcF[31:INDEX_BITS+2], pcF[1:0]};

   // Fetch lookup: PC word index, optionally folded with zero-extended history.
   always_comb begin
      idxF = pcF[INDEX_BITS+1:2];
      if (MODE == 1) idxF = idxF ^ INDEX_BITS'(ghr_q);
      predF = ctr_q[idxF][CTR_BITS-1];
   end

   // Next-state for training, history, Decode registers and statistics.
   always_comb begin
      ctr_upd_d       = ctr_step(ctr_q[update_index], update_taken);
      ghr_d           = ghr_q;
      branch_count_d  = branch_count_q;
      mispred_count_d = mispred_count_q;
      if (update_en) begin
         if (MODE == 1) ghr_d = HIST_BITS'({ghr_q, update_taken});
         branch_count_d  = branch_count_q + 32'd1;
         mispred_count_d = mispred_count_q + 32'(update_mispredict);
      end
      pred_take_d  = pred_take_q;
      pred_index_d = pred_index_q;
      if (flushD) begin
         pred_take_d  = 1'b0;
         pred_index_d = '0;
      end else if (!stallD) begin
         pred_take_d  = predF;
         pred_index_d = idxF;
      end
   end

   // Counter table: reset to weakly not-taken, written only on resolution.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
      end else if (update_en) begin
         ctr_q[update_index] <= ctr_upd_d;
      end
   end

   // History, Decode prediction and statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_q           <= '0;
         pred_take_q     <= 1'b0;
         pred_index_q    <= '0;
         branch_count_q  <= '0;
         mispred_count_q <= '0;
      end else begin
         ghr_q           <= ghr_d;
         pred_take_q     <= pred_take_d;
         pred_index_q    <= pred_index_d;
         branch_count_q  <= branch_count_d;
         mispred_count_q <= mispred_count_d;
      end
   end

   assign pred_takeD    = pred_take_q;
   assign pred_indexD   = pred_index_q;
   assign branch_count  = branch_count_q;
   assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed stimulus with a queue-based scoreboard.
// dut0 is bimodal (INDEX_BITS=4), dutg is gshare (INDEX_BITS=4, HIST_BITS=4).
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;

   logic [31:0] pcF;
   logic        stallD, flushD, take0;
   logic [3:0]  index0;
   logic        upd_en, upd_tk, upd_mp;
   logic [3:0]  upd_idx;
   logic [31:0] bc0, mc0;

   logic [31:0] g_pcF;
   logic        g_stallD, g_flushD, g_take;
   logic [3:0]  g_index;
   logic        g_upd_en, g_upd_tk, g_upd_mp;
   logic [3:0]  g_upd_idx;
   logic [31:0] g_bc, g_mc;

   branch_predictor #(.INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(4), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
      .pred_takeD(take0), .pred_indexD(index0), .update_en(upd_en),
      .update_index(upd_idx), .update_taken(upd_tk), .update_mispredict(upd_mp),
      .branch_count(bc0), .mispred_count(mc0));

   branch_predictor #(.INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(4), .MODE(1)) dutg (
      .clk(clk), .rst(rst), .pcF(g_pcF), .stallD(g_stallD), .flushD(g_flushD),
      .pred_takeD(g_take), .pred_indexD(g_index), .update_en(g_upd_en),
      .update_index(g_upd_idx), .update_taken(g_upd_tk), .update_mispredict(g_upd_mp),
      .branch_count(g_bc), .mispred_count(g_mc));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      int          sel;
      logic [31:0] v;
   } sb_t;
   sb_t sb[$];

   int checks = 0;
   int errors = 0;
   int tail_g = 0;
   int tail_b = 0;
   logic [31:0] exp_bc = 0;
   logic [31:0] exp_mc = 0;

   string names [10] = '{"take0", "index0", "branch_count0", "mispred_count0",
                         "g_take", "g_index", "g_branch_count", "g_mispred_count",
                         "gshare_tail_mispredicts", "bimodal_tail_ge_half"};

   function automatic logic [31:0] actual(input int sel);
      case (sel)
         0: return 32'(take0);
         1: return 32'(index0);
         2: return bc0;
         3: return mc0;
         4: return 32'(g_take);
         5: return 32'(g_index);
         6: return g_bc;
         7: return g_mc;
         8: return 32'(tail_g);
         default: return 32'(tail_b >= 4);
      endcase
   endfunction

   // Monitor: compare every expectation that falls due on this cycle.
   always @(negedge clk) begin
      logic [31:0] a;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            checks++;
            a = actual(sb[i].sel);
            if (sb[i].due < cyc) begin
               errors++;
               $display("FAIL %s stale expectation due=%0d cyc=%0d", names[sb[i].sel], sb[i].due, cyc);
            end else if (a !== sb[i].v) begin
               errors++;
               $display("FAIL %s cyc=%0d got=%0h want=%0h", names[sb[i].sel], cyc, a, sb[i].v);
            end
            sb.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_push(input int sel, input logic [31:0] v, input int d);
      sb.push_back('{due: cyc + d, sel: sel, v: v});
   endtask

   task automatic upd(input logic [3:0] i, input logic t, input logic m);
      upd_en = 1'b1; upd_idx = i; upd_tk = t; upd_mp = m;
      exp_bc = exp_bc + 32'd1;
      exp_mc = exp_mc + 32'(m);
      step();
      upd_en = 1'b0;
      exp_push(2, exp_bc, 0);
      exp_push(3, exp_mc, 0);
   endtask

   task automatic g_upd(input logic [3:0] i, input logic t);
      g_upd_en = 1'b1; g_upd_idx = i; g_upd_tk = t; g_upd_mp = 1'b0;
      step();
      g_upd_en = 1'b0;
   endtask

   initial begin
      logic       p0, pg, outcome;
      logic [3:0] i0, ig;
      rst = 1'b1; pcF = 32'h0040_0010; stallD = 0; flushD = 0;
      upd_en = 0; upd_idx = 0; upd_tk = 0; upd_mp = 0;
      g_pcF = 0; g_stallD = 0; g_flushD = 0;
      g_upd_en = 0; g_upd_idx = 0; g_upd_tk = 0; g_upd_mp = 0;

      // reset state
      step();
      exp_push(0, 0, 0); exp_push(1, 0, 0); exp_push(2, 0, 0); exp_push(3, 0, 0);
      rst = 1'b0;
      exp_push(0, 0, 1); exp_push(1, 4, 1);
      step();

      // saturation on index 4
      upd(4, 1, 0); upd(4, 1, 0); upd(4, 1, 0);
      exp_push(0, 1, 1); step();
      for (int k = 0; k < 4; k++) begin
         exp_push(0, 1, 1);
         upd(4, 1, 0);
      end
      exp_push(0, 1, 1); step();
      upd(4, 0, 0); exp_push(0, 1, 1); step();
      upd(4, 0, 1); exp_push(0, 0, 1); step();
      upd(4, 0, 0); upd(4, 0, 0); exp_push(0, 0, 1); step();
      upd(4, 1, 0); exp_push(0, 0, 1); step();
      upd(4, 1, 0); exp_push(0, 1, 1); step();

      // stall / flush on the predicted-taken entry 4
      exp_push(0, 1, 1); exp_push(1, 4, 1); step();
      stallD = 1; pcF = 32'h0040_0020;
      exp_push(0, 1, 1); exp_push(1, 4, 1); step();
      pcF = 32'h0040_003C;
      exp_push(0, 1, 1); exp_push(1, 4, 1); step();
      flushD = 1;
      exp_push(0, 0, 1); exp_push(1, 0, 1); step();
      flushD = 0; stallD = 0; pcF = 32'h0040_0010;
      exp_push(0, 1, 1); exp_push(1, 4, 1); step();

      // same-cycle lookup and update of index 7 (counter 1)
      pcF = 32'h0040_001C;
      exp_push(0, 0, 1); exp_push(1, 7, 1);
      upd(7, 1, 0);
      exp_push(0, 1, 1); step();

      // reset mid-operation discards a same-cycle update
      rst = 1; pcF = 32'h0040_0010;
      upd_en = 1; upd_idx = 4; upd_tk = 1; upd_mp = 1;
      step();
      rst = 0; upd_en = 0;
      exp_push(0, 0, 0); exp_push(1, 0, 0); exp_push(2, 0, 0); exp_push(3, 0, 0);
      exp_bc = 0; exp_mc = 0;
      exp_push(0, 0, 1); exp_push(1, 4, 1); step();

      // statistics: 10 updates, 3 mispredicted
      for (int k = 0; k < 10; k++) upd(9, 1, (k == 2 || k == 5 || k == 8));
      exp_push(2, 10, 0); exp_push(3, 3, 0);
      step();
      force dut0.branch_count_q = 32'hFFFF_FFFF;
      #1;
      release dut0.branch_count_q;
      exp_bc = 32'hFFFF_FFFF;
      upd(9, 1, 0);
      exp_push(2, 0, 0);

      // gshare history 1,0,1,1 -> GHR=1011
      rst = 1; step(); rst = 0;
      g_upd(0, 1); g_upd(0, 0); g_upd(0, 1); g_upd(0, 1);
      exp_push(6, 4, 0);
      g_pcF = 32'h0000_0000;
      exp_push(5, 11, 1); exp_push(4, 0, 1);
      step();

      // alternating T/N on one PC: gshare vs bimodal
      rst = 1; step(); rst = 0;
      for (int it = 0; it < 16; it++) begin
         pcF = 32'h0000_0014; g_pcF = 32'h0000_0014;
         step();
         p0 = take0; i0 = index0; pg = g_take; ig = g_index;
         outcome = ((it % 2) == 0);
         if (it >= 8) begin
            tail_b += (p0 != outcome) ? 1 : 0;
            tail_g += (pg != outcome) ? 1 : 0;
         end
         upd_en = 1; upd_idx = i0; upd_tk = outcome; upd_mp = (p0 != outcome);
         g_upd_en = 1; g_upd_idx = ig; g_upd_tk = outcome; g_upd_mp = (pg != outcome);
         step();
         upd_en = 0; g_upd_en = 0;
      end
      exp_push(8, 0, 0); exp_push(9, 1, 0);
      exp_push(6, 16, 0); exp_push(7, 3, 0);
      step(); step();

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
